// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared FSM state, owner encoding and default access length for sram_port_arbiter
package sram_arb_pkg;
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_t;
   localparam int ACCESS_CYCLES_DEF = 2;
endpackage

// File: rtl/sram_arb_pick.sv
// sram_arb_pick: grant selector; fixed D-over-IF, or round-robin on contention when SRAM_ARB_RR_EN is defined
module sram_arb_pick
   import sram_arb_pkg::*;
(
   input  logic   if_req,
   input  logic   d_req,
`ifdef SRAM_ARB_RR_EN
   input  owner_t last,
`endif
   output owner_t owner
);
`ifdef SRAM_ARB_RR_EN
   assign owner = (if_req & d_req) ? ((last == OWN_IF) ? OWN_D : OWN_IF) : (d_req ? OWN_D : OWN_IF);
`else
   assign owner = (d_req | ~if_req) ? OWN_D : OWN_IF;
`endif
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port sram between IF and D with fixed-length registered accesses
// Optional round-robin on contention via macro SRAM_ARB_RR_EN.
module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEF,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   output logic              busy,
   output logic              mem_cs,
   output logic              mem_oe,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout
);
   localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
   state_t state, state_n;
   owner_t own, own_n, pick;
   logic [CW-1:0] cnt, cnt_n;
   logic cs_n, oe_n, we_n, if_ack_n, d_ack_n;
   logic [ADDR_W-1:0] addr_n;
   logic [DATA_W-1:0] din_n, if_rdata_n, d_rdata_n;
`ifdef SRAM_ARB_RR_EN
   owner_t last, last_n;
   sram_arb_pick u_pick (.if_req(if_req), .d_req(d_req), .last(last), .owner(pick));
`else
   sram_arb_pick u_pick (.if_req(if_req), .d_req(d_req), .owner(pick));
`endif

   always_comb begin
      state_n = state;
      own_n = own;
      cnt_n = cnt;
      cs_n = mem_cs;
      oe_n = mem_oe;
      we_n = mem_we;
      addr_n = mem_addr;
      din_n = mem_din;
      if_rdata_n = if_rdata;
      d_rdata_n = d_rdata;
      if_ack_n = 1'b0;
      d_ack_n = 1'b0;
`ifdef SRAM_ARB_RR_EN
      last_n = last;
`endif
      case (state)
         IDLE: if (if_req | d_req) begin
            state_n = ACCESS;
            own_n = pick;
            cnt_n = CW'(ACCESS_CYCLES - 1);
            cs_n = 1'b1;
            we_n = (pick == OWN_D) & d_we;
            oe_n = ~we_n;
            addr_n = (pick == OWN_D) ? d_addr : if_addr;
            din_n = (pick == OWN_D) ? d_wdata : mem_din;
`ifdef SRAM_ARB_RR_EN
            last_n = pick;
`endif
         end
         ACCESS: if (cnt == '0) begin
            // read data is sampled on the same edge that releases the sram
            state_n = DONE;
            cs_n = 1'b0;
            oe_n = 1'b0;
            we_n = 1'b0;
            if_rdata_n = (own == OWN_IF) ? mem_dout : if_rdata;
            d_rdata_n = (own == OWN_D && !mem_we) ? mem_dout : d_rdata;
            if_ack_n = (own == OWN_IF);
            d_ack_n = (own == OWN_D);
         end else begin
            cnt_n = cnt - CW'(1);
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         own <= OWN_IF;
         cnt <= '0;
         mem_cs <= 1'b0;
         mem_oe <= 1'b0;
         mem_we <= 1'b0;
         mem_addr <= '0;
         mem_din <= '0;
         if_rdata <= '0;
         d_rdata <= '0;
         if_ack <= 1'b0;
         d_ack <= 1'b0;
         busy <= 1'b0;
      end else begin
         state <= state_n;
         own <= own_n;
         cnt <= cnt_n;
         mem_cs <= cs_n;
         mem_oe <= oe_n;
         mem_we <= we_n;
         mem_addr <= addr_n;
         mem_din <= din_n;
         if_rdata <= if_rdata_n;
         d_rdata <= d_rdata_n;
         if_ack <= if_ack_n;
         d_ack <= d_ack_n;
         busy <= (state_n != IDLE);
      end
   end

`ifdef SRAM_ARB_RR_EN
   always_ff @(posedge clk) begin
      if (reset) last <= OWN_IF;
      else last <= last_n;
   end
`endif
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed checks of sram_port_arbiter with ACCESS_CYCLES=2 (dut a) and 1 (dut b)
module tb_sram_port_arbiter;
   logic clk = 1'b0;
   logic reset;
   logic if_req, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_din, mem_dout;
   logic if_ack, d_ack, busy, mem_cs, mem_oe, mem_we;
   logic b_if_req;
   logic [31:0] b_if_addr, b_if_rdata, b_d_rdata, b_mem_addr, b_mem_din, b_mem_dout;
   logic b_if_ack, b_d_ack, b_busy, b_mem_cs, b_mem_oe, b_mem_we;
   logic [31:0] zero32 = '0;
   logic zero1 = 1'b0;
   logic [31:0] ram [0:255];
   logic [31:0] a_prev_addr, b_prev_addr;
   logic a_prev_cs, b_prev_cs;
   int checks = 0, errors = 0, inv_bad = 0;
   logic [31:0] exp_addr;

   always #5 clk = ~clk;

   sram_port_arbiter #(.ACCESS_CYCLES(2)) dut_a (
      .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
      .busy(busy), .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_dout(mem_dout));

   sram_port_arbiter #(.ACCESS_CYCLES(1)) dut_b (
      .clk(clk), .reset(reset), .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
      .d_req(zero1), .d_we(zero1), .d_addr(zero32), .d_wdata(zero32), .d_rdata(b_d_rdata), .d_ack(b_d_ack),
      .busy(b_busy), .mem_cs(b_mem_cs), .mem_oe(b_mem_oe), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
      .mem_din(b_mem_din), .mem_dout(b_mem_dout));

   // word-addressed sram model for dut a; dut b reads a value derived from its address
   assign mem_dout = ram[mem_addr[9:2]];
   assign b_mem_dout = b_mem_addr ^ 32'hA5A5A5A5;

   always @(posedge clk) begin
      if (mem_cs && mem_we) ram[mem_addr[9:2]] <= mem_din;
      if (reset === 1'b0) begin
         if ((mem_oe & mem_we) || (b_mem_oe & b_mem_we)) inv_bad <= inv_bad + 1;
         if (a_prev_cs && mem_cs && mem_addr !== a_prev_addr) inv_bad <= inv_bad + 1;
         if (b_prev_cs && b_mem_cs && b_mem_addr !== b_prev_addr) inv_bad <= inv_bad + 1;
      end
      a_prev_cs <= mem_cs;
      a_prev_addr <= mem_addr;
      b_prev_cs <= b_mem_cs;
      b_prev_addr <= b_mem_addr;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = '0;
      ram[1] = 32'h20080005;
      reset = 1'b1;
      if_req = 0; d_req = 0; d_we = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
      b_if_req = 0; b_if_addr = 0;
      tick();
      tick();
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_cs", {31'd0, mem_cs}, 0);
      chk("rst_acks", {30'd0, if_ack, d_ack}, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      reset = 1'b0;
      tick();
      // IF read at 4
      if_req = 1; if_addr = 32'h4;
      tick();
      chk("if_g_ctl", {29'd0, mem_cs, mem_oe, mem_we}, 3'b110);
      chk("if_g_addr", mem_addr, 32'h4);
      chk("if_g_busy", {31'd0, busy}, 1);
      chk("if_g_ack", {31'd0, if_ack}, 0);
      tick();
      chk("if_a2_ctl", {29'd0, mem_cs, mem_oe, mem_we}, 3'b110);
      chk("if_a2_ack", {31'd0, if_ack}, 0);
      tick();
      chk("if_ack", {30'd0, if_ack, d_ack}, 2'b10);
      chk("if_rdata", if_rdata, 32'h20080005);
      chk("if_done_cs", {31'd0, mem_cs}, 0);
      chk("if_done_addr", mem_addr, 32'h4);
      if_req = 0;
      tick();
      chk("if_ack_drop", {30'd0, if_ack, d_ack}, 0);
      chk("if_idle_busy", {31'd0, busy}, 0);
      // D store then load at 0x100
      d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
      tick();
      chk("st_g_ctl", {29'd0, mem_cs, mem_oe, mem_we}, 3'b101);
      chk("st_g_din", mem_din, 32'hDEADBEEF);
      tick();
      chk("st_a2_ctl", {29'd0, mem_cs, mem_oe, mem_we}, 3'b101);
      tick();
      chk("st_ack", {30'd0, if_ack, d_ack}, 2'b01);
      chk("st_done_ctl", {29'd0, mem_cs, mem_oe, mem_we}, 3'b000);
      d_req = 0;
      tick();
      chk("st_ack_drop", {31'd0, d_ack}, 0);
      d_req = 1; d_we = 0; d_wdata = 32'h0;
      tick();
      chk("ld_g_ctl", {29'd0, mem_cs, mem_oe, mem_we}, 3'b110);
      tick();
      tick();
      chk("ld_ack", {30'd0, if_ack, d_ack}, 2'b01);
      chk("ld_rdata", d_rdata, 32'hDEADBEEF);
      chk("ld_if_hold", if_rdata, 32'h20080005);
      d_req = 0;
      tick();
      chk("ld_ack_drop", {31'd0, d_ack}, 0);
      // contention from a fresh reset: first grant D, then fixed or alternating
      reset = 1'b1;
      tick();
      reset = 1'b0;
      if_req = 1; if_addr = 32'h4; d_req = 1; d_addr = 32'h100;
      for (int i = 0; i < 4; i++) begin
`ifdef SRAM_ARB_RR_EN
         exp_addr = (i % 2 == 0) ? 32'h100 : 32'h4;
`else
         exp_addr = 32'h100;
`endif
         tick();
         chk($sformatf("both_g%0d_addr", i), mem_addr, exp_addr);
         tick();
         tick();
         chk($sformatf("both_g%0d_ack", i), {30'd0, if_ack, d_ack}, (exp_addr == 32'h100) ? 2'b01 : 2'b10);
         if (i == 3) d_req = 0;
         tick();
      end
      tick();
      chk("if_after_d_addr", mem_addr, 32'h4);
      chk("if_after_d_cs", {31'd0, mem_cs}, 1);
      tick();
      tick();
      chk("if_after_d_ack", {30'd0, if_ack, d_ack}, 2'b10);
      if_req = 0;
      tick();
      // reset in the second ACCESS cycle of a load
      d_req = 1; d_we = 0; d_addr = 32'h100;
      tick();
      tick();
      reset = 1'b1; d_req = 0;
      tick();
      chk("rma_cs", {31'd0, mem_cs}, 0);
      chk("rma_busy", {31'd0, busy}, 0);
      chk("rma_ack", {30'd0, if_ack, d_ack}, 0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("rma_noack%0d", i), {30'd0, if_ack, d_ack}, 0);
      end
      if_req = 1; if_addr = 32'h4;
      tick();
      tick();
      tick();
      chk("rma_new_ack", {30'd0, if_ack, d_ack}, 2'b10);
      chk("rma_new_rdata", if_rdata, 32'h20080005);
      if_req = 0;
      tick();
      // ACCESS_CYCLES=1, IF held high: one ack every 3 cycles
      b_if_req = 1;
      for (int i = 0; i < 3; i++) begin
         b_if_addr = 32'h8 + 32'(i) * 4;
         tick();
         chk($sformatf("b%0d_grant", i), {30'd0, b_mem_cs, b_if_ack}, 2'b10);
         chk($sformatf("b%0d_addr", i), b_mem_addr, 32'h8 + 32'(i) * 4);
         tick();
         chk($sformatf("b%0d_ack", i), {31'd0, b_if_ack}, 1);
         chk($sformatf("b%0d_rdata", i), b_if_rdata, (32'h8 + 32'(i) * 4) ^ 32'hA5A5A5A5);
         tick();
         chk($sformatf("b%0d_idle", i), {30'd0, b_if_ack, b_busy}, 0);
      end
      b_if_req = 0;
      tick();
      chk("invariants", 32'(inv_bad), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
